// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-port arbiter and standby/wake sequencer for the cascaded 32-bit SPRAM
// Optional round-robin arbitration when SPRAM_ARB_ROUND_ROBIN_EN is defined; fixed priority (port 0 first) otherwise.
module spram_arbiter #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [13:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [3:0]  be0,
  input  logic        req1,
  input  logic        we1,
  input  logic [13:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be1,
  output logic        ack0,
  output logic        ack1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [7:0]  mem_mask_wren,
  output logic        mem_wren,
  output logic        mem_chip_sel,
  output logic        mem_standby,
  output logic        mem_sleep,
  output logic        mem_poweroff,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_e;

  localparam int IDLE_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 2) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;

  logic        any_req;
  logic        issue_en;
  logic        pick1;
  logic        gnt0;
  logic        gnt1;
  logic        sel_we;
  logic [13:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;

  function automatic logic [7:0] nibble_mask(input logic [3:0] be);
    logic [7:0] m;
    for (int k = 0; k < 4; k++) begin
      m[2*k +: 2] = {2{be[k]}};
    end
    return m;
  endfunction

  assign any_req = req0 | req1;
  // Grants are only issued from ACTIVE; reset suppresses them so nothing reaches the SPRAM during reset.
  assign issue_en = (state_q == ST_ACTIVE) && !reset;

`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  assign pick1 = req1 && (!req0 || rr_q);

  always_comb begin
    rr_d = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign pick1 = req1 && !req0;
`endif

  assign gnt0 = issue_en && req0 && !pick1;
  assign gnt1 = issue_en && pick1;

  assign sel_we    = pick1 ? we1    : we0;
  assign sel_addr  = pick1 ? addr1  : addr0;
  assign sel_wdata = pick1 ? wdata1 : wdata0;
  assign sel_be    = pick1 ? be1    : be0;

  always_comb begin
    ack0          = 1'b0;
    ack1          = 1'b0;
    mem_chip_sel  = 1'b0;
    mem_addr      = 14'd0;
    mem_data_in   = 32'd0;
    mem_wren      = 1'b0;
    mem_mask_wren = 8'd0;
    if (gnt0 || gnt1) begin
      ack0          = gnt0;
      ack1          = gnt1;
      mem_chip_sel  = 1'b1;
      mem_addr      = sel_addr;
      mem_data_in   = sel_wdata;
      mem_wren      = sel_we;
      mem_mask_wren = sel_we ? nibble_mask(sel_be) : 8'd0;
    end
  end

  assign mem_standby  = (state_q == ST_STANDBY) && !reset;
  assign mem_sleep    = 1'b0;
  assign mem_poweroff = 1'b1;

  // Read data flows straight from the SPRAM; the tag registers say whose read it is.
  assign rvalid0_d = gnt0 && !we0;
  assign rvalid1_d = gnt1 && !we1;
  assign rvalid0   = rvalid0_q && !reset;
  assign rvalid1   = rvalid1_q && !reset;
  assign rdata     = mem_data_out;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        if (any_req) begin
          idle_cnt_d = '0;
        end else if ((IDLE_CYCLES != 0) && (idle_cnt_q == IDLE_LAST)) begin
          state_d    = ST_STANDBY;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != {IDLE_W{1'b1}}) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_STANDBY: begin
        if (any_req) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Standby stays low for WAKE_CYCLES before the first access is issued.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-port arbiter and power sequencer in front of the 32-bit x 16K-word cascaded SPRAM data memory (two 16-bit SPRAM halves sharing address and control).
- Port 0 serves the processor data path. Port 1 serves a secondary master (debug/DMA loader).
- Converts per-byte enables to nibble write masks and issues at most one access per cycle.
- Places the SPRAM in standby after an idle period and sequences the wake-up before the next access.

Parameters:
- IDLE_CYCLES, 16: consecutive idle cycles before entering standby; 0 = never enter standby.
- WAKE_CYCLES, 3: cycles standby must be deasserted before the first access after wake; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held high until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  14  word address
- wdata0 / wdata1  in  32  write data
- be0 / be1  in  4  byte enables; bit k = byte [8k+7:8k]
- ack0 / ack1  out  1  one-cycle pulse in the cycle the access is issued to the SPRAM
- rvalid0 / rvalid1  out  1  one-cycle pulse, the cycle after a read ack
- rdata  out  32  read data, valid when rvalid0 or rvalid1 is high
- mem_addr  out  14  SPRAM address
- mem_data_in  out  32  SPRAM write data
- mem_mask_wren  out  8  nibble write mask; byte k drives bits 2k+1:2k
- mem_wren  out  1  SPRAM write enable
- mem_chip_sel  out  1  SPRAM chip select
- mem_standby  out  1  SPRAM standby
- mem_sleep  out  1  tied 0
- mem_poweroff  out  1  tied 1 (powered)
- mem_data_out  in  32  SPRAM read data

Behaviour:
- Reset:
  - Outputs: all acks and rvalids = 0; mem_chip_sel = 0; mem_wren = 0; mem_standby = 0; mem_mask_wren = 0; mem_addr = 0.
  - Internal: state = ACTIVE; idle counter = 0; rr pointer = 0.
- Reset asserted mid-access: any pending rvalid is dropped.
- States:
  - ACTIVE:
    - Any req present: grant one requester this cycle.
    - Issue combinationally from the registered state: mem_chip_sel = 1, mem_addr/mem_data_in/mem_wren from the winner, mem_mask_wren = nibble-expanded be when writing, 0 when reading. Pulse ack for the winner.
    - No req: idle counter increments, saturating. At count == IDLE_CYCLES-1 with no req (and IDLE_CYCLES != 0), go to STANDBY.
    - Any req resets the idle counter to 0.
  - STANDBY:
    - mem_standby = 1; mem_chip_sel = 0; no acks.
    - Any req: go to WAKE next cycle and clear the wake counter.
  - WAKE:
    - mem_standby = 0; no acks.
    - Wake counter increments each cycle. At WAKE_CYCLES-1, go to ACTIVE.
    - Requests stay pending through WAKE and are served in ACTIVE.
- Arbitration (default fixed priority): port 0 wins whenever req0 = 1.
- Read latency: ack cycle N, then rvalidX = 1 with rdata = mem_data_out in cycle N+1.
  - A registered tag records which port issued the read.
  - Back-to-back reads from alternating ports are allowed, one per cycle.
- Writes produce no rvalid.
- be = 0 write: still acked; mask is 0, so memory is unchanged.
- Both reqs arriving in STANDBY: single wake sequence, then normal arbitration.
- A requester deasserting req before ack is permitted; nothing is issued for it.
- Throughput: one access per cycle in ACTIVE, with no bubble between grants.

Optional Feature:
- Macro: SPRAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - On simultaneous req0 and req1, the preferred port wins and the pointer flips to the other port.
  - A single requester always wins, and the pointer moves to the other port.
- Undefined: fixed priority, port 0 first. No pointer register exists.

Test Plan:
- Write then read, port 0: addr0 = 0x0123, wdata0 = 0xDEADBEEF, be0 = 0xF, then read 0x0123.
  - Write ack, mem_mask_wren = 0xFF.
  - Read: rvalid0 one cycle after ack, rdata = 0xDEADBEEF.
- Byte write: be0 = 0x4, wdata0 = 0x00AA0000 over 0x11223344.
  - mem_mask_wren = 0x30; readback 0x11AA3344.
- Contention, fixed priority: req0 and req1 high for 4 cycles.
  - ack0 every cycle, ack1 never.
  - With the macro: acks alternate 0, 1, 0, 1, starting with port 0.
- Standby entry and wake, IDLE_CYCLES = 16, WAKE_CYCLES = 3:
  - After 16 idle cycles, mem_standby = 1.
  - req1 read then raised: mem_standby falls the next cycle, ack1 arrives exactly 3 cycles later, rvalid1 the cycle after.
- Reset mid-read: assert reset in the cycle after a read ack.
  - rvalid0 = 0, all outputs at reset values, state ACTIVE, and the first request after reset is acked immediately.
- Pipelined alternating reads: req0 read 0x10, then req1 read 0x20.
  - rvalid0 then rvalid1 on consecutive cycles, each with the correct data.
